param_code_detonator: RTL and testbench

Parametrised successor to the team's 4-digit code detonator. Adds:
- configurable code length;
- a retry counter with timed lockout;
- an operator code-change mode;
- a scanned 4-digit seven-segment display showing the last entered digits.

Sits at top level on pynq-z2, driven by debounced single-cycle button pulses.

---
 rtl/detonator_pkg.sv | 48 ++++
 rtl/param_code_detonator_seg_scan.sv | 42 ++++
 rtl/param_code_detonator.sv | 231 +++++++++++++++++++++++
 tb/tb_param_code_detonator.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detonator_pkg.sv
// Shared state encoding, segment constants and the BCD-to-segment decoder
// used by the parametrised code detonator and its display scanner.
package detonator_pkg;

  localparam logic [3:0] ST_WAIT_ENC    = 4'd0;
  localparam logic [3:0] ST_READY_ENC   = 4'd1;
  localparam logic [3:0] ST_ENTRY_ENC   = 4'd2;
  localparam logic [3:0] ST_CHECK_ENC   = 4'd3;
  localparam logic [3:0] ST_OK_ENC      = 4'd4;
  localparam logic [3:0] ST_FIRE_ENC    = 4'd5;
  localparam logic [3:0] ST_ERROR_ENC   = 4'd6;
  localparam logic [3:0] ST_LOCK_ENC    = 4'd7;
  localparam logic [3:0] ST_NEWCODE_ENC = 4'd8;

  typedef enum logic [3:0] {
    ST_WAIT    = ST_WAIT_ENC,
    ST_READY   = ST_READY_ENC,
    ST_ENTRY   = ST_ENTRY_ENC,
    ST_CHECK   = ST_CHECK_ENC,
    ST_OK      = ST_OK_ENC,
    ST_FIRE    = ST_FIRE_ENC,
    ST_ERROR   = ST_ERROR_ENC,
    ST_LOCK    = ST_LOCK_ENC,
    ST_NEWCODE = ST_NEWCODE_ENC
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segments abcdefg with a as MSB, active-low; non-BCD values show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/param_code_detonator_seg_scan.sv
// Four-position seven-segment scanner: rotates the active digit every
// SCAN_MAX+1 clocks and registers enable and segments on the same edge.
module seg_scan
  import detonator_pkg::*;
#(
  parameter int SCAN_MAX = 49_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  valid,
  output logic [3:0]  en,
  output logic [6:0]  m_disp
);

  localparam int CW = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_MAX);

  logic [CW-1:0] cnt;
  logic [1:0]    pos;
  logic [1:0]    pos_next;
  logic          wrap;

  assign wrap     = (cnt == SCAN_LAST);
  assign pos_next = wrap ? pos + 2'd1 : pos;

  // Outputs are built from pos_next so en and m_disp move together with pos.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      pos    <= 2'd0;
      en     <= 4'b1110;
      m_disp <= SEG_BLANK;
    end else begin
      cnt    <= wrap ? '0 : cnt + CW'(1);
      pos    <= pos_next;
      en     <= ~(4'b0001 << pos_next);
      m_disp <= valid[pos_next] ? bcd_to_seg(digits[4*pos_next +: 4]) : SEG_BLANK;
    end
  end

endmodule

// File: rtl/param_code_detonator.sv
// Parametrised code detonator: BCD code entry with retry lockout, operator
// code change and a scanned display of the most recently entered digits.
module param_code_detonator
  import detonator_pkg::*;
#(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] INIT_CODE   = 16'h2580,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  BLINK_MAX   = 25_000_000,
  parameter int                  LOCK_CYCLES = 250_000_000,
  parameter int                  SCAN_MAX    = 49_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wait_t,
  input  logic       setup,
  input  logic       ready,
  input  logic       fire,
  input  logic       sure,
  input  logic       change,
  input  logic [3:0] A,
  input  logic       confirm,
  output logic       lt,
  output logic       bt,
  output logic       rt,
  output logic [3:0] en,
  output logic [6:0] m_disp,
  output logic       locked
);

  localparam int W  = 4 * DIGITS;
  localparam int BW = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [3:0]    DIGITS_L   = 4'(DIGITS);
  localparam logic [3:0]    TRIES_LAST = 4'(MAX_TRIES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MAX);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);

  state_t        state, state_next;
  logic [W-1:0]  code, code_next;
  logic [W-1:0]  buffer, buffer_next;
  logic [W-1:0]  buffer_shift;
  logic [3:0]    idx, idx_next;
  logic [3:0]    tries, tries_next;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic [LW-1:0] lock_cnt;
  logic          lock_done;
  logic          digit_ok;
  logic          entry_full;
  logic          show_digits;
  logic [15:0]   digit_vec;
  logic [3:0]    valid_mask;

  assign digit_ok     = confirm && (A <= 4'd9);
  assign entry_full   = (idx == DIGITS_L);
  assign buffer_shift = {buffer[W-5:0], A};
  assign lock_done    = (lock_cnt == LOCK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_WAIT;
      code   <= INIT_CODE;
      buffer <= '0;
      idx    <= 4'd0;
      tries  <= 4'd0;
    end else begin
      state  <= state_next;
      code   <= code_next;
      buffer <= buffer_next;
      idx    <= idx_next;
      tries  <= tries_next;
    end
  end

  // Each state checks its inputs in the fixed priority fire > sure > confirm > change > wait_t > ready/setup.
  always_comb begin
    state_next  = state;
    code_next   = code;
    buffer_next = buffer;
    idx_next    = idx;
    tries_next  = tries;
    case (state)
      ST_WAIT: begin
        if (fire) begin
          state_next = ST_ERROR;
        end else if (ready) begin
          state_next  = ST_READY;
          buffer_next = '0;
          idx_next    = 4'd0;
        end
      end
      ST_READY: begin
        if (fire || sure) begin
          state_next = ST_ERROR;
        end else if (digit_ok) begin
          state_next  = ST_ENTRY;
          buffer_next = buffer_shift;
          idx_next    = 4'd1;
        end else if (wait_t) begin
          state_next = ST_WAIT;
        end
      end
      ST_ENTRY: begin
        if (fire) begin
          state_next = ST_ERROR;
        end else if (sure) begin
          state_next = entry_full ? ST_CHECK : ST_ERROR;
        end else if (digit_ok) begin
          if (entry_full) begin
            state_next = ST_ERROR;
          end else begin
            buffer_next = buffer_shift;
            idx_next    = idx + 4'd1;
          end
        end else if (wait_t) begin
          state_next = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (buffer == code) begin
          state_next = ST_OK;
          tries_next = 4'd0;
        end else if (tries == TRIES_LAST) begin
          state_next = ST_LOCK;
          tries_next = 4'd0;
        end else begin
          state_next = ST_ERROR;
          tries_next = tries + 4'd1;
        end
      end
      ST_OK: begin
        if (fire) begin
          state_next = ST_FIRE;
        end else if (change) begin
          state_next  = ST_NEWCODE;
          buffer_next = '0;
          idx_next    = 4'd0;
        end else if (wait_t) begin
          state_next = ST_WAIT;
        end
      end
      ST_FIRE: begin
        state_next = ST_WAIT;
      end
      // Fire here only aborts the change; it never detonates.
      ST_NEWCODE: begin
        if (fire) begin
          state_next = ST_OK;
        end else if (sure) begin
          if (entry_full) begin
            code_next  = buffer;
            state_next = ST_WAIT;
          end else begin
            state_next = ST_OK;
          end
        end else if (digit_ok && !entry_full) begin
          buffer_next = buffer_shift;
          idx_next    = idx + 4'd1;
        end
      end
      ST_ERROR: begin
        if (setup) state_next = ST_WAIT;
      end
      ST_LOCK: begin
        if (lock_done) state_next = ST_WAIT;
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

  // Held at zero outside ERROR so every ERROR entry starts with the LED off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state != ST_ERROR) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
    end else if (state != ST_LOCK) begin
      lock_cnt <= '0;
    end else if (!lock_done) begin
      lock_cnt <= lock_cnt + LW'(1);
    end
  end

  assign lt     = (state == ST_OK);
  assign bt     = (state == ST_FIRE);
  assign locked = (state == ST_LOCK);
  assign rt     = (state == ST_LOCK) || ((state == ST_ERROR) && blink);

  assign show_digits = (state == ST_READY) || (state == ST_ENTRY) ||
                       (state == ST_CHECK) || (state == ST_NEWCODE);

  // Only the four newest digits reach the display; short codes pad with blanks.
  for (genvar p = 0; p < 4; p++) begin : g_digit
    if (p < DIGITS) begin : g_used
      assign digit_vec[4*p +: 4] = buffer[4*p +: 4];
      assign valid_mask[p]       = show_digits && (idx > 4'(p));
    end else begin : g_unused
      assign digit_vec[4*p +: 4] = 4'd0;
      assign valid_mask[p]       = 1'b0;
    end
  end

  seg_scan #(
    .SCAN_MAX (SCAN_MAX)
  ) u_seg_scan (
    .clk    (clk),
    .rst    (rst),
    .digits (digit_vec),
    .valid  (valid_mask),
    .en     (en),
    .m_disp (m_disp)
  );

endmodule

// File: tb/tb_param_code_detonator.sv
// Bench for param_code_detonator: directed scenarios plus random pulses, all
// checked every cycle against a digit-queue model of the detonator's rules.
module tb_param_code_detonator;

  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int BLINK_MAX   = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int SCAN_MAX    = 1;

  localparam int B_WAIT    = 1;
  localparam int B_SETUP   = 2;
  localparam int B_READY   = 4;
  localparam int B_FIRE    = 8;
  localparam int B_SURE    = 16;
  localparam int B_CHANGE  = 32;
  localparam int B_CONFIRM = 64;

  localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wait_t = 1'b0, setup = 1'b0, ready = 1'b0, fire = 1'b0;
  logic       sure = 1'b0, change = 1'b0, confirm = 1'b0;
  logic [3:0] A = 4'd0;
  logic       lt, bt, rt, locked;
  logic [3:0] en;
  logic [6:0] m_disp;

  int tests_run = 0;
  int tests_failed = 0;

  typedef enum {M_WAIT, M_READY, M_ENTRY, M_CHECK, M_OK, M_FIRE, M_ERROR, M_LOCK, M_NEWCODE} mstate_t;
  mstate_t    m_state;
  int         entered[$];
  int         code[$];
  int         m_tries, m_age, m_edges;
  logic [3:0] exp_en;
  logic [6:0] exp_disp;
  logic [3:0] en_seen [8];

  always #5 clk = ~clk;

  param_code_detonator #(
    .DIGITS      (DIGITS),
    .INIT_CODE   (16'h2580),
    .MAX_TRIES   (MAX_TRIES),
    .BLINK_MAX   (BLINK_MAX),
    .LOCK_CYCLES (LOCK_CYCLES),
    .SCAN_MAX    (SCAN_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wait_t  (wait_t),
    .setup   (setup),
    .ready   (ready),
    .fire    (fire),
    .sure    (sure),
    .change  (change),
    .A       (A),
    .confirm (confirm),
    .lt      (lt),
    .bt      (bt),
    .rt      (rt),
    .en      (en),
    .m_disp  (m_disp),
    .locked  (locked)
  );

  task automatic expect_eq(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic bit codes_match();
    if (entered.size() != code.size()) return 1'b0;
    for (int i = 0; i < code.size(); i++)
      if (entered[i] != code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state  = M_WAIT;
    entered.delete();
    code     = '{2, 5, 8, 0};
    m_tries  = 0;
    m_age    = 0;
    m_edges  = 0;
    exp_en   = 4'b1110;
    exp_disp = 7'h7F;
  endtask

  // Display uses the pre-edge digits and the post-edge scan position.
  task automatic model_step();
    mstate_t nxt;
    bit      vc;
    int      pos;
    bit      show;
    m_edges++;
    pos    = (m_edges / (SCAN_MAX + 1)) % 4;
    exp_en = ~(4'b0001 << pos);
    show   = m_state inside {M_READY, M_ENTRY, M_CHECK, M_NEWCODE};
    if (show && pos < entered.size()) exp_disp = SEG_TAB[entered[entered.size() - 1 - pos]];
    else exp_disp = 7'h7F;
    vc  = confirm && (A <= 4'd9);
    nxt = m_state;
    case (m_state)
      M_WAIT: begin
        if (fire) nxt = M_ERROR;
        else if (ready) begin nxt = M_READY; entered.delete(); end
      end
      M_READY: begin
        if (fire || sure) nxt = M_ERROR;
        else if (vc) begin entered.push_back(int'(A)); nxt = M_ENTRY; end
        else if (wait_t) nxt = M_WAIT;
      end
      M_ENTRY: begin
        if (fire) nxt = M_ERROR;
        else if (sure) nxt = (entered.size() == DIGITS) ? M_CHECK : M_ERROR;
        else if (vc) begin
          if (entered.size() == DIGITS) nxt = M_ERROR;
          else entered.push_back(int'(A));
        end else if (wait_t) nxt = M_WAIT;
      end
      M_CHECK: begin
        if (codes_match()) begin nxt = M_OK; m_tries = 0; end
        else if (m_tries + 1 == MAX_TRIES) begin nxt = M_LOCK; m_tries = 0; end
        else begin nxt = M_ERROR; m_tries++; end
      end
      M_OK: begin
        if (fire) nxt = M_FIRE;
        else if (change) begin nxt = M_NEWCODE; entered.delete(); end
        else if (wait_t) nxt = M_WAIT;
      end
      M_FIRE: nxt = M_WAIT;
      M_NEWCODE: begin
        if (fire) nxt = M_OK;
        else if (sure) begin
          if (entered.size() == DIGITS) begin code = entered; nxt = M_WAIT; end
          else nxt = M_OK;
        end else if (vc && entered.size() < DIGITS) entered.push_back(int'(A));
      end
      M_ERROR: if (setup) nxt = M_WAIT;
      M_LOCK:  if (m_age == LOCK_CYCLES - 1) nxt = M_WAIT;
      default: nxt = M_WAIT;
    endcase
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  task automatic checkOutput();
    logic exp_rt;
    exp_rt = (m_state == M_LOCK) ||
             ((m_state == M_ERROR) && (((m_age / (BLINK_MAX + 1)) % 2) == 1));
    expect_eq("lt", lt, m_state == M_OK);
    expect_eq("bt", bt, m_state == M_FIRE);
    expect_eq("locked", locked, m_state == M_LOCK);
    expect_eq("rt", rt, exp_rt);
    expect_eq("en", en, exp_en);
    expect_eq("m_disp", m_disp, exp_disp);
  endtask

  always @(negedge clk) begin
    if (rst) checkOutput();
  end

  task automatic clear_inputs();
    wait_t = 0; setup = 0; ready = 0; fire = 0; sure = 0; change = 0; confirm = 0;
  endtask

  task automatic applyStimulus(input int flags, input logic [3:0] digit);
    wait_t  = flags[0];
    setup   = flags[1];
    ready   = flags[2];
    fire    = flags[3];
    sure    = flags[4];
    change  = flags[5];
    confirm = flags[6];
    A       = digit;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    applyStimulus(B_READY, 4'd0);
    for (int i = 3; i >= 0; i--) applyStimulus(B_CONFIRM, c[4*i +: 4]);
    applyStimulus(B_SURE, 4'd0);
  endtask

  task automatic check_reset_values(input string tag);
    expect_eq({tag, "_lt"}, lt, 1'b0);
    expect_eq({tag, "_bt"}, bt, 1'b0);
    expect_eq({tag, "_rt"}, rt, 1'b0);
    expect_eq({tag, "_locked"}, locked, 1'b0);
    expect_eq({tag, "_en"}, en, 4'b1110);
    expect_eq({tag, "_m_disp"}, m_disp, 7'b1111111);
  endtask

  // Reset is asserted and released between clock edges.
  task automatic do_reset(input bit check_now);
    #2 rst = 1'b0;
    #1 if (check_now) check_reset_values("async_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic expect_error_blink(input string tag);
    expect_eq({tag, "_rt_off"}, rt, 1'b0);
    expect_eq({tag, "_lt"}, lt, 1'b0);
    idle(4);
    expect_eq({tag, "_rt_on"}, rt, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    #2 rst = 1'b1;
    @(negedge clk);

    // Correct code, fire.
    enter_code(16'h2580);
    expect_eq("s1_check_lt", lt, 1'b0);
    idle(1);
    expect_eq("s1_ok_lt", lt, 1'b1);
    applyStimulus(B_FIRE, 4'd0);
    expect_eq("s1_fire_bt", bt, 1'b1);
    idle(1);
    expect_eq("s1_wait_bt", bt, 1'b0);
    expect_eq("s1_wait_lt", lt, 1'b0);

    // Three wrong codes lead to LOCK.
    for (int k = 0; k < 2; k++) begin
      enter_code(16'h1111);
      idle(1);
      expect_eq("s2_rt_t0", rt, 1'b0);
      idle(3);
      expect_eq("s2_rt_t3", rt, 1'b0);
      idle(1);
      expect_eq("s2_rt_t4", rt, 1'b1);
      idle(3);
      expect_eq("s2_rt_t7", rt, 1'b1);
      idle(1);
      expect_eq("s2_rt_t8", rt, 1'b0);
      applyStimulus(B_SETUP, 4'd0);
    end
    enter_code(16'h1111);
    idle(1);
    expect_eq("s2_lock_rt", rt, 1'b1);
    expect_eq("s2_lock_locked", locked, 1'b1);
    applyStimulus(B_SETUP, 4'd0);
    idle(17);
    expect_eq("s2_lock_t18", locked, 1'b1);
    idle(1);
    expect_eq("s2_lock_t19", locked, 1'b1);
    idle(1);
    expect_eq("s2_unlock_locked", locked, 1'b0);
    expect_eq("s2_unlock_rt", rt, 1'b0);

    // Short entry, overrun, invalid digit.
    applyStimulus(B_READY, 4'd0);
    applyStimulus(B_CONFIRM, 4'd2);
    applyStimulus(B_CONFIRM, 4'd5);
    applyStimulus(B_CONFIRM, 4'd8);
    applyStimulus(B_SURE, 4'd0);
    expect_error_blink("s3_short");
    applyStimulus(B_SETUP, 4'd0);
    applyStimulus(B_READY, 4'd0);
    for (int i = 0; i < 5; i++) applyStimulus(B_CONFIRM, 4'(i + 1));
    expect_error_blink("s3_overrun");
    applyStimulus(B_SETUP, 4'd0);
    applyStimulus(B_READY, 4'd0);
    applyStimulus(B_CONFIRM, 4'd2);
    applyStimulus(B_CONFIRM, 4'hC);
    applyStimulus(B_CONFIRM, 4'd5);
    applyStimulus(B_CONFIRM, 4'd8);
    applyStimulus(B_CONFIRM, 4'd0);
    applyStimulus(B_SURE, 4'd0);
    idle(1);
    expect_eq("s3_invalid_ignored_lt", lt, 1'b1);

    // Code change to 1234, then reset restores 2580.
    applyStimulus(B_CHANGE, 4'd0);
    for (int i = 1; i <= 4; i++) applyStimulus(B_CONFIRM, 4'(i));
    applyStimulus(B_SURE, 4'd0);
    expect_eq("s4_newcode_wait_lt", lt, 1'b0);
    enter_code(16'h2580);
    idle(1);
    expect_error_blink("s4_old_code");
    applyStimulus(B_SETUP, 4'd0);
    enter_code(16'h1234);
    idle(1);
    expect_eq("s4_new_code_lt", lt, 1'b1);
    do_reset(1'b0);
    enter_code(16'h2580);
    idle(1);
    expect_eq("s4_reset_code_lt", lt, 1'b1);
    applyStimulus(B_WAIT, 4'd0);

    // Display of 7,3 while in ENTRY.
    applyStimulus(B_READY, 4'd0);
    applyStimulus(B_CONFIRM, 4'd7);
    applyStimulus(B_CONFIRM, 4'd3);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      en_seen[i] = en;
      if (en == 4'b1110) expect_eq("s5_disp_p0", m_disp, 7'b0000110);
      else if (en == 4'b1101) expect_eq("s5_disp_p1", m_disp, 7'b0001111);
      else expect_eq("s5_disp_blank", m_disp, 7'b1111111);
      idle(1);
    end
    for (int i = 0; i < 6; i++)
      expect_eq("s5_en_rotate", en_seen[i + 2], {en_seen[i][2:0], en_seen[i][3]});
    applyStimulus(B_WAIT, 4'd0);

    // Simultaneous fire and sure, then async reset mid-entry.
    applyStimulus(B_READY, 4'd0);
    applyStimulus(B_CONFIRM, 4'd2);
    applyStimulus(B_CONFIRM, 4'd5);
    applyStimulus(B_FIRE | B_SURE, 4'd0);
    expect_error_blink("s6_fire_sure");
    applyStimulus(B_SETUP, 4'd0);
    applyStimulus(B_READY, 4'd0);
    applyStimulus(B_CONFIRM, 4'd2);
    applyStimulus(B_CONFIRM, 4'd5);
    do_reset(1'b1);

    // Random pulses, biased toward the stored code digits.
    for (int n = 0; n < 3000; n++) begin
      int         r;
      int         flags;
      logic [3:0] d;
      r = $urandom_range(0, 99);
      if (r < 40)      flags = B_CONFIRM;
      else if (r < 48) flags = B_SURE;
      else if (r < 51) flags = B_FIRE;
      else if (r < 60) flags = B_READY;
      else if (r < 72) flags = B_SETUP;
      else if (r < 76) flags = B_WAIT;
      else if (r < 80) flags = B_CHANGE;
      else             flags = 0;
      if ($urandom_range(0, 9) == 0) flags = flags | (1 << $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0 && entered.size() < DIGITS) d = 4'(code[entered.size()]);
      else d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) do_reset(1'b0);
      else applyStimulus(flags, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
